// File: rtl/uart_link_ctrl_pkg.sv
// Shared types and constants for the UART link controller: FSM encoding,
// frame marker, drive-command bit positions and counter widths.
package uart_link_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_GAP       = 2'd3
   } state_t;

   localparam logic FRAME_MARK = 1'b1;

   localparam int CMD_FWD   = 0;
   localparam int CMD_BACK  = 1;
   localparam int CMD_LEFT  = 2;
   localparam int CMD_RIGHT = 3;

   localparam int TMR_W = 16;
   localparam int ERR_W = 8;

   // Opposing requests on one axis cancel each other out.
   function automatic logic [3:0] sanitize_cmd(input logic [3:0] c);
      logic [3:0] s;
      s = c;
      if (c[CMD_FWD] && c[CMD_BACK]) begin
         s[CMD_FWD]  = 1'b0;
         s[CMD_BACK] = 1'b0;
      end
      if (c[CMD_LEFT] && c[CMD_RIGHT]) begin
         s[CMD_LEFT]  = 1'b0;
         s[CMD_RIGHT] = 1'b0;
      end
      return s;
   endfunction

endpackage

// File: rtl/uart_link_ctrl_timeout.sv
// Millisecond timeout: counts tick pulses up to LIMIT and holds there;
// clear has priority over a same-cycle tick.
module ms_timeout
   import uart_link_ctrl_pkg::*;
#(
   parameter int LIMIT = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic clr,
   output logic expired
);

   localparam logic [TMR_W-1:0] LIM = TMR_W'(LIMIT);

   logic [TMR_W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (tick && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == LIM);

endmodule

// File: rtl/uart_link_ctrl.sv
// UART link controller: sends drive-command / heartbeat frames, supervises
// the transmitter with a timeout and tracks incoming sensor frames.
//
// state        | meaning
// ST_IDLE      | waiting for a pending command or heartbeat
// ST_LOAD      | frame latched, tx_start pulsed
// ST_WAIT_DONE | waiting for tx_done or TX timeout
// ST_GAP       | one-cycle spacer before the next frame
module uart_link_ctrl
   import uart_link_ctrl_pkg::*;
#(
   parameter int HB_PERIOD_MS  = 20,
   parameter int TX_TIMEOUT_MS = 5,
   parameter int RX_TIMEOUT_MS = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_ms,
   input  logic [3:0]       cmd,
   input  logic             cmd_valid,
   output logic [7:0]       tx_data,
   output logic             tx_start,
   input  logic             tx_done,
   input  logic [7:0]       rx_data,
   input  logic             rx_ready,
   input  logic             rx_error,
   output logic [3:0]       sensors,
   output logic             link_ok,
   output logic             tx_fault,
   output logic [ERR_W-1:0] rx_err_cnt
);

   state_t     state;
   logic [3:0] mailbox;
   logic [3:0] cmd_cur;
   logic [3:0] cmd_san;
   logic [3:0] cmd_next;
   logic       cmd_pend;
   logic       hb_pend;
   logic       load;
   logic       hb_exp;
   logic       tx_exp;
   logic       rx_exp;
   logic       rx_good;
   logic       unused_rx;

   assign cmd_san   = sanitize_cmd(cmd);
   assign load      = (state == ST_IDLE) && (cmd_pend || hb_pend);
   assign cmd_next  = load ? mailbox : cmd_cur;
   assign rx_good   = rx_ready && !rx_error;
   assign unused_rx = ^rx_data[7:4];

   // Any frame, command or heartbeat, restarts the heartbeat interval.
   ms_timeout #(.LIMIT(HB_PERIOD_MS)) u_hb_tmr (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick_ms),
      .clr     (hb_exp || load),
      .expired (hb_exp)
   );

   ms_timeout #(.LIMIT(TX_TIMEOUT_MS)) u_tx_tmr (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick_ms),
      .clr     (state != ST_WAIT_DONE),
      .expired (tx_exp)
   );

   ms_timeout #(.LIMIT(RX_TIMEOUT_MS)) u_rx_tmr (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick_ms),
      .clr     (rx_good),
      .expired (rx_exp)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         tx_start <= 1'b0;
         tx_data  <= {FRAME_MARK, 7'b000_0000};
         cmd_cur  <= 4'h0;
         mailbox  <= 4'h0;
         cmd_pend <= 1'b0;
         hb_pend  <= 1'b0;
         tx_fault <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         if (hb_exp) hb_pend <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (load) begin
                  state    <= ST_LOAD;
                  tx_start <= 1'b1;
                  cmd_cur  <= mailbox;
                  tx_data  <= {FRAME_MARK, 3'b000, mailbox};
                  cmd_pend <= 1'b0;
                  hb_pend  <= 1'b0;
               end
            end
            ST_LOAD: state <= ST_WAIT_DONE;
            ST_WAIT_DONE: begin
               if (tx_done) begin
                  state <= ST_GAP;
               end else if (tx_exp) begin
                  state    <= ST_IDLE;
                  tx_fault <= 1'b1;
               end
            end
            ST_GAP:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
         // A new write compares against whatever cmd_cur will be after this edge.
         if (cmd_valid) begin
            mailbox  <= cmd_san;
            cmd_pend <= (cmd_san != cmd_next);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sensors    <= 4'h0;
         link_ok    <= 1'b0;
         rx_err_cnt <= '0;
      end else begin
         if (rx_good) begin
            sensors <= rx_data[3:0];
            link_ok <= 1'b1;
         end else if (rx_exp) begin
            sensors <= 4'h0;
            link_ok <= 1'b0;
         end
         if (rx_ready && rx_error && (rx_err_cnt != {ERR_W{1'b1}})) begin
            rx_err_cnt <= rx_err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Bench for uart_link_ctrl: scoreboard of expected frame bytes pushed as
// commands/ticks are driven, popped whenever tx_start is seen.
module tb_uart_link_ctrl;

   localparam int HB = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_ms;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_done;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_error;
   logic [3:0] sensors;
   logic       link_ok;
   logic       tx_fault;
   logic [7:0] rx_err_cnt;

   int         total = 0;
   int         bad = 0;
   int         nframes = 0;
   int         unexp = 0;
   int         cyc_no = 0;
   int         last_start = -1;
   int         hb_cnt = 0;
   int         done_reqs = 0;
   int         done_seen = 0;
   int         dly = 0;
   int         n0;
   logic       auto_done = 1'b1;
   logic [3:0] m_cur = 4'h0;
   logic [7:0] exp_q[$];

   uart_link_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .tick_ms    (tick_ms),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_done    (tx_done),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .rx_error   (rx_error),
      .sensors    (sensors),
      .link_ok    (link_ok),
      .tx_fault   (tx_fault),
      .rx_err_cnt (rx_err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] clean(input logic [3:0] c);
      logic [3:0] r;
      r = c;
      if (c == (c | 4'b0011)) r = r & 4'b1100;
      if (c == (c | 4'b1100)) r = r & 4'b0011;
      return r;
   endfunction

   task automatic send_cmd(input logic [3:0] c);
      logic [3:0] s;
      s = clean(c);
      if (s != m_cur) begin
         m_cur = s;
         hb_cnt = 0;
         exp_q.push_back({4'b1000, s});
      end
      cmd = c;
      cmd_valid = 1'b1;
      cyc(1);
      cmd_valid = 1'b0;
   endtask

   task automatic model_tick();
      hb_cnt++;
      if (hb_cnt == HB) begin
         hb_cnt = 0;
         exp_q.push_back({4'b1000, m_cur});
      end
   endtask

   task automatic tick();
      tick_ms = 1'b1;
      cyc(1);
      tick_ms = 1'b0;
      model_tick();
      cyc(10);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic rx(input logic [7:0] d, input logic e);
      rx_data = d;
      rx_error = e;
      rx_ready = 1'b1;
      cyc(1);
      rx_ready = 1'b0;
      rx_error = 1'b0;
   endtask

   // Transmitter model: automatic tx_done two cycles after tx_start, or on request.
   initial begin
      tx_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tx_done = 1'b0;
         if (dly > 0) begin
            dly--;
            if (dly == 0) tx_done = 1'b1;
         end
         if (done_seen != done_reqs) begin
            tx_done = 1'b1;
            done_seen = done_reqs;
         end
         if (tx_start && auto_done) dly = 2;
      end
   end

   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         cyc_no++;
         if (tx_start) begin
            nframes++;
            if (last_start >= 0) chk("start_spacing", 32'(cyc_no - last_start >= 3), 32'd1);
            last_start = cyc_no;
            if (exp_q.size() == 0) begin
               unexp++;
            end else begin
               e = exp_q.pop_front();
               chk("frame_data", 32'(tx_data), 32'(e));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      tick_ms = 1'b0;
      cmd = 4'h0;
      cmd_valid = 1'b0;
      rx_data = 8'h00;
      rx_ready = 1'b0;
      rx_error = 1'b0;
      cyc(3);
      chk("rst_tx_data", 32'(tx_data), 32'h80);
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_link_ok", 32'(link_ok), 32'd0);
      chk("rst_sensors", 32'(sensors), 32'd0);
      chk("rst_tx_fault", 32'(tx_fault), 32'd0);
      chk("rst_err_cnt", 32'(rx_err_cnt), 32'd0);
      rst = 1'b1;
      cyc(3);

      // Forward command issues a frame right away.
      send_cmd(4'b0001);
      cyc(1);
      chk("cmd_start", 32'(tx_start), 32'd1);
      chk("cmd_data", 32'(tx_data), 32'h81);
      cyc(10);

      // Cancelling commands resolve to 0 and send nothing once cmd_cur is 0.
      send_cmd(4'b0000);
      cyc(10);
      send_cmd(4'b0011);
      send_cmd(4'b1100);
      send_cmd(4'b1111);
      cyc(10);
      n0 = nframes;
      ticks(HB - 1);
      chk("hb_early", 32'(nframes), 32'(n0));
      tick();
      chk("hb_frame", 32'(nframes), 32'(n0 + 1));

      // Commands during WAIT_DONE are held; last write wins.
      auto_done = 1'b0;
      n0 = nframes;
      send_cmd(4'b0001);
      cyc(4);
      send_cmd(4'b0001);
      send_cmd(4'b0100);
      cyc(3);
      chk("held_count", 32'(nframes), 32'(n0 + 1));
      done_reqs++;
      cyc(8);
      chk("held_sent", 32'(nframes), 32'(n0 + 2));
      done_reqs++;
      cyc(5);
      auto_done = 1'b1;
      cyc(10);
      chk("held_once", 32'(nframes), 32'(n0 + 2));

      // TX timeout sets the sticky fault; later frames still go out.
      auto_done = 1'b0;
      send_cmd(4'b1011);
      cyc(4);
      ticks(4);
      chk("txto_early", 32'(tx_fault), 32'd0);
      tick();
      chk("txto_fault", 32'(tx_fault), 32'd1);
      done_reqs++;
      cyc(3);
      auto_done = 1'b1;
      n0 = nframes;
      send_cmd(4'b0010);
      cyc(10);
      chk("txto_next", 32'(nframes), 32'(n0 + 1));
      chk("txto_sticky", 32'(tx_fault), 32'd1);

      // Good RX frames, simultaneous tick/rx, and RX silence timeout.
      rx(8'h05, 1'b0);
      chk("rx_sensors", 32'(sensors), 32'h5);
      chk("rx_link", 32'(link_ok), 32'd1);
      ticks(99);
      chk("rx_99_link", 32'(link_ok), 32'd1);
      tick_ms = 1'b1;
      rx(8'h03, 1'b0);
      tick_ms = 1'b0;
      model_tick();
      cyc(10);
      chk("rx_tick_sens", 32'(sensors), 32'h3);
      ticks(99);
      chk("rx_clr_link", 32'(link_ok), 32'd1);
      chk("rx_clr_sens", 32'(sensors), 32'h3);
      tick();
      chk("rxto_link", 32'(link_ok), 32'd0);
      chk("rxto_sens", 32'(sensors), 32'h0);

      // Error frames saturate the counter and leave sensors alone.
      rx(8'h0A, 1'b0);
      chk("rx_sens_a", 32'(sensors), 32'hA);
      for (int i = 0; i < 300; i++) begin
         rx(8'hAF, 1'b1);
         if (i == 99) chk("err_100", 32'(rx_err_cnt), 32'd100);
         if (i == 253) chk("err_254", 32'(rx_err_cnt), 32'd254);
         if (i == 254) chk("err_255", 32'(rx_err_cnt), 32'd255);
      end
      chk("err_sat", 32'(rx_err_cnt), 32'd255);
      chk("err_sens", 32'(sensors), 32'hA);
      chk("err_link", 32'(link_ok), 32'd1);

      // Reset in WAIT_DONE abandons the frame; next one is a heartbeat later.
      auto_done = 1'b0;
      send_cmd(4'b0001);
      cyc(4);
      rst = 1'b0;
      cyc(2);
      chk("rst2_tx_data", 32'(tx_data), 32'h80);
      chk("rst2_fault", 32'(tx_fault), 32'd0);
      chk("rst2_err", 32'(rx_err_cnt), 32'd0);
      chk("rst2_sens", 32'(sensors), 32'd0);
      m_cur = 4'h0;
      hb_cnt = 0;
      auto_done = 1'b1;
      rst = 1'b1;
      cyc(3);
      n0 = nframes;
      ticks(HB - 1);
      chk("rst2_quiet", 32'(nframes), 32'(n0));
      tick();
      chk("rst2_hb", 32'(nframes), 32'(n0 + 1));

      cyc(10);
      chk("sb_left", 32'(exp_q.size()), 32'd0);
      chk("sb_unexp", 32'(unexp), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
